// File: rtl/rs_pkg.sv
// ============================================================================
// Module      : rs_pkg
// Description : Shared types and constants for the RS encoder control slice:
//               FSM state encoding, default code geometry and the
//               symbol-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_pkg;

  // Default code geometry: RS(255,239), 16 parity symbols.
  localparam int unsigned c_n_default = 255;
  localparam int unsigned c_k_default = 239;

  // Encoder control phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } rs_state_t;

  // The symbol counter must hold values up to N-1, so it is clog2(N) bits wide.
  // A floor of 1 keeps the vector legal for degenerate N.
  function automatic int unsigned rs_cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_sym_counter.sv
// ============================================================================
// Module      : rs_sym_counter
// Description : Loadable up-counter with enable and a terminal-count compare.
//               The terminal value is an input, so a single counter serves
//               both the message and the parity phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_sym_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] tc_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] r_cnt;

  // Load has priority over increment so a terminal acceptance restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
  assign tc  = (r_cnt == tc_val);

endmodule

`default_nettype wire

// File: rtl/rs_enc_ctrl.sv
// ============================================================================
// Module      : rs_enc_ctrl
// Description : Control sequencer for a systematic Reed-Solomon encoder.
//               Steers an external parity LFSR through clear / feed /
//               shift-out so each codeword is K message symbols followed by
//               N-K parity symbols, with valid/ready on both sides.
//               Optional frame-length check: RS_ENC_CTRL_LAST_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_enc_ctrl
  import rs_pkg::*;
#(
  parameter int N = c_n_default,
  parameter int K = c_k_default
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic out_sel,
  output logic lfsr_clr,
  output logic lfsr_shift,
  output logic lfsr_fb,
  output logic err_len
);

  localparam int                c_cw     = rs_cnt_width(N);
  localparam logic [c_cw-1:0]   c_msg_tc = c_cw'(K - 1);
  localparam logic [c_cw-1:0]   c_par_tc = c_cw'(N - K - 1);

  rs_state_t        r_state;
  rs_state_t        w_state_nxt;
  logic             w_accept;
  logic             w_msg_accept;
  logic             w_load;
  logic             w_tc;
  logic [c_cw-1:0]  w_tc_val;
  logic [c_cw-1:0]  w_cnt;

  // Terminal count tracks the phase; kept outside the FSM block so the
  // compare result feeding the FSM has no block-level feedback.
  assign w_tc_val = (r_state == PAR) ? c_par_tc : c_msg_tc;

  // Terminal acceptance restarts the counter for the next phase.
  assign w_load = w_accept & w_tc;

  rs_sym_counter #(
    .WIDTH (c_cw)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (w_accept),
    .load     (w_load),
    .load_val ('0),
    .tc_val   (w_tc_val),
    .cnt      (w_cnt),
    .tc       (w_tc)
  );

  // State register; reset drops any partial codeword.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/datapath controls; framing is driven by the
  // symbol count alone, never by in_last.
  always_comb begin
    w_state_nxt  = r_state;
    lfsr_clr     = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_sel      = 1'b0;
    lfsr_fb      = 1'b0;
    lfsr_shift   = 1'b0;
    out_last     = 1'b0;
    w_accept     = 1'b0;
    w_msg_accept = 1'b0;
    case (r_state)
      IDLE: begin
        lfsr_clr    = 1'b1;
        w_state_nxt = MSG;
      end
      MSG: begin
        lfsr_fb      = 1'b1;
        in_ready     = out_ready;
        out_valid    = in_valid;
        lfsr_shift   = in_valid & out_ready;
        w_accept     = in_valid & out_ready;
        w_msg_accept = in_valid & out_ready;
        if (w_accept && w_tc) begin
          w_state_nxt = PAR;
        end
      end
      PAR: begin
        out_sel    = 1'b1;
        out_valid  = 1'b1;
        lfsr_shift = out_ready;
        w_accept   = out_ready;
        out_last   = w_tc;
        if (w_accept && w_tc) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef RS_ENC_CTRL_LAST_CHECK_EN
  logic r_err_len;

  // Flag an accepted message symbol whose in_last disagrees with the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_len <= 1'b0;
    end else begin
      r_err_len <= w_msg_accept & (in_last != w_tc);
    end
  end

  assign err_len = r_err_len;
`else
  logic w_unused_in_last;
  logic w_unused_msg_accept;

  assign w_unused_in_last    = in_last;
  assign w_unused_msg_accept = w_msg_accept;
  assign err_len             = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rs_enc_ctrl.sv
// ============================================================================
// Module      : tb_rs_enc_ctrl
// Description : Directed self-checking bench for rs_enc_ctrl. A small RS(6,4)
//               instance covers framing, stalls, gaps, length check and reset;
//               a default RS(255,239) instance covers the full-size frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_enc_ctrl;

`ifdef RS_ENC_CTRL_LAST_CHECK_EN
  localparam logic c_chk = 1'b1;
`else
  localparam logic c_chk = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  logic s_in_ready, s_out_valid, s_out_last, s_out_sel;
  logic s_lfsr_clr, s_lfsr_shift, s_lfsr_fb, s_err_len;
  logic d_in_ready, d_out_valid, d_out_last, d_out_sel;
  logic d_lfsr_clr, d_lfsr_shift, d_lfsr_fb, d_err_len;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rs_enc_ctrl #(.N(6), .K(4)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_last    (in_last),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_last   (s_out_last),
    .out_sel    (s_out_sel),
    .lfsr_clr   (s_lfsr_clr),
    .lfsr_shift (s_lfsr_shift),
    .lfsr_fb    (s_lfsr_fb),
    .err_len    (s_err_len)
  );

  rs_enc_ctrl dut_d (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (d_in_ready),
    .in_last    (in_last),
    .out_valid  (d_out_valid),
    .out_ready  (out_ready),
    .out_last   (d_out_last),
    .out_sel    (d_out_sel),
    .lfsr_clr   (d_lfsr_clr),
    .lfsr_shift (d_lfsr_shift),
    .lfsr_fb    (d_lfsr_fb),
    .err_len    (d_err_len)
  );

  // Output bundle: {clr, in_ready, out_valid, sel, fb, shift, last, err}
  logic [7:0] obs_s, obs_d;
  assign obs_s = {s_lfsr_clr, s_in_ready, s_out_valid, s_out_sel,
                  s_lfsr_fb, s_lfsr_shift, s_out_last, s_err_len};
  assign obs_d = {d_lfsr_clr, d_in_ready, d_out_valid, d_out_sel,
                  d_lfsr_fb, d_lfsr_shift, d_out_last, d_err_len};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge, in the first IDLE cycle.
  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_last = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    exp = 8'b1000_0000;
    total++;
    if (obs_s !== exp) begin
      bad++;
      $display("FAIL reset_small got=%b want=%b", obs_s, exp);
    end
    total++;
    if (obs_d !== exp) begin
      bad++;
      $display("FAIL reset_default got=%b want=%b", obs_d, exp);
    end
    tick();
    total++;
    if (obs_s !== exp) begin
      bad++;
      $display("FAIL reset_hold got=%b want=%b", obs_s, exp);
    end
  endtask

  // Rows: {in_valid, out_ready, in_last, expected[7:0]}
  task automatic test_nominal();
    logic [10:0] tbl [15];
    logic [7:0]  exp;
    tbl = '{11'b110_1000_0000, 11'b110_0110_1100, 11'b110_0110_1100,
            11'b110_0110_1100, 11'b111_0110_1100, 11'b110_0011_0100,
            11'b110_0011_0110,
            11'b110_1000_0000, 11'b110_0110_1100, 11'b110_0110_1100,
            11'b110_0110_1100, 11'b111_0110_1100, 11'b110_0011_0100,
            11'b110_0011_0110, 11'b110_1000_0000};
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      in_valid  = tbl[i][10];
      out_ready = tbl[i][9];
      in_last   = tbl[i][8];
      exp = {tbl[i][7:1], tbl[i][0] & c_chk};
      #1;
      total++;
      if (obs_s !== exp) begin
        bad++;
        $display("FAIL nominal cyc=%0d got=%b want=%b", i, obs_s, exp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] tbl [14];
    logic [7:0]  exp;
    tbl = '{11'b110_1000_0000, 11'b110_0110_1100,
            11'b100_0010_1000, 11'b100_0010_1000, 11'b100_0010_1000,
            11'b110_0110_1100, 11'b110_0110_1100, 11'b111_0110_1100,
            11'b100_0011_0000, 11'b100_0011_0000, 11'b100_0011_0000,
            11'b110_0011_0100, 11'b110_0011_0110, 11'b110_1000_0000};
    reset_dut();
    for (int i = 0; i < 14; i++) begin
      in_valid  = tbl[i][10];
      out_ready = tbl[i][9];
      in_last   = tbl[i][8];
      exp = {tbl[i][7:1], tbl[i][0] & c_chk};
      #1;
      total++;
      if (obs_s !== exp) begin
        bad++;
        $display("FAIL backpressure cyc=%0d got=%b want=%b", i, obs_s, exp);
      end
      tick();
    end
  endtask

  task automatic test_source_gaps();
    logic [10:0] tbl [11];
    logic [7:0]  exp;
    tbl = '{11'b110_1000_0000, 11'b110_0110_1100, 11'b010_0100_1000,
            11'b110_0110_1100, 11'b010_0100_1000, 11'b110_0110_1100,
            11'b010_0100_1000, 11'b111_0110_1100, 11'b010_0011_0100,
            11'b010_0011_0110, 11'b010_1000_0000};
    reset_dut();
    for (int i = 0; i < 11; i++) begin
      in_valid  = tbl[i][10];
      out_ready = tbl[i][9];
      in_last   = tbl[i][8];
      exp = {tbl[i][7:1], tbl[i][0] & c_chk};
      #1;
      total++;
      if (obs_s !== exp) begin
        bad++;
        $display("FAIL source_gaps cyc=%0d got=%b want=%b", i, obs_s, exp);
      end
      tick();
    end
  endtask

  // Frame A: early in_last on symbol 3; frame B: in_last missing on symbol 4.
  // The err bit is expected only when the length check is built in.
  task automatic test_length_check();
    logic [10:0] tbl [15];
    logic [7:0]  exp;
    tbl = '{11'b110_1000_0000, 11'b110_0110_1100, 11'b110_0110_1100,
            11'b111_0110_1100, 11'b111_0110_1101, 11'b110_0011_0100,
            11'b110_0011_0110,
            11'b110_1000_0000, 11'b110_0110_1100, 11'b110_0110_1100,
            11'b110_0110_1100, 11'b110_0110_1100, 11'b110_0011_0101,
            11'b110_0011_0110, 11'b110_1000_0000};
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      in_valid  = tbl[i][10];
      out_ready = tbl[i][9];
      in_last   = tbl[i][8];
      exp = {tbl[i][7:1], tbl[i][0] & c_chk};
      #1;
      total++;
      if (obs_s !== exp) begin
        bad++;
        $display("FAIL length_check cyc=%0d got=%b want=%b", i, obs_s, exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_par();
    logic [10:0] pre [6];
    logic [10:0] post [8];
    logic [7:0]  exp;
    pre  = '{11'b110_1000_0000, 11'b110_0110_1100, 11'b110_0110_1100,
             11'b110_0110_1100, 11'b111_0110_1100, 11'b110_0011_0100};
    post = '{11'b110_1000_0000, 11'b110_0110_1100, 11'b110_0110_1100,
             11'b110_0110_1100, 11'b111_0110_1100, 11'b110_0011_0100,
             11'b110_0011_0110, 11'b110_1000_0000};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      in_valid  = pre[i][10];
      out_ready = pre[i][9];
      in_last   = pre[i][8];
      exp = {pre[i][7:1], pre[i][0] & c_chk};
      #1;
      total++;
      if (obs_s !== exp) begin
        bad++;
        $display("FAIL rst_par_pre cyc=%0d got=%b want=%b", i, obs_s, exp);
      end
      tick();
    end
    // Now in PAR after parity symbol 1; reset must act without a clock edge.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_last   = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (obs_s !== 8'b1000_0000) begin
      bad++;
      $display("FAIL rst_par_async got=%b want=%b", obs_s, 8'b1000_0000);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid  = post[i][10];
      out_ready = post[i][9];
      in_last   = post[i][8];
      exp = {post[i][7:1], post[i][0] & c_chk};
      #1;
      total++;
      if (obs_s !== exp) begin
        bad++;
        $display("FAIL rst_par_post cyc=%0d got=%b want=%b", i, obs_s, exp);
      end
      tick();
    end
  endtask

  task automatic test_default_params();
    logic [7:0] exp;
    int         lasts;
    lasts = 0;
    reset_dut();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_last   = 1'b0;
    #1;
    total++;
    if (obs_d !== 8'b1000_0000) begin
      bad++;
      $display("FAIL default_idle got=%b want=%b", obs_d, 8'b1000_0000);
    end
    tick();
    for (int i = 0; i < 255; i++) begin
      in_last = (i == 238);
      if (i < 239) exp = 8'b0110_1100;
      else         exp = {7'b0011_010, 1'b0} | ((i == 254) ? 8'b0000_0010 : 8'b0);
      #1;
      if (d_out_last === 1'b1) lasts++;
      total++;
      if (obs_d !== exp) begin
        bad++;
        $display("FAIL default_sym sym=%0d got=%b want=%b", i + 1, obs_d, exp);
      end
      tick();
    end
    in_last = 1'b0;
    #1;
    total++;
    if (obs_d !== 8'b1000_0000) begin
      bad++;
      $display("FAIL default_gap got=%b want=%b", obs_d, 8'b1000_0000);
    end
    total++;
    if (lasts != 1) begin
      bad++;
      $display("FAIL default_last_count got=%0d want=1", lasts);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_source_gaps();
    test_length_check();
    test_reset_mid_par();
    test_default_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
